// File: rtl/sram_controller_pkg.sv
// Shared widths, address map base and FSM state encoding for the SRAM controller.
package sram_controller_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int SRAM_ADDR_WIDTH = 18;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int MEM_BASE        = 1024;

    // IDLE -> LO (low half-word) -> HI (high half-word) -> DONE -> IDLE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage data-memory responder: one 32-bit request becomes two half-word
// accesses on an external asynchronous 16-bit SRAM; ready stalls the pipeline.
module sram_controller #(
    parameter int WORD_WIDTH      = sram_controller_pkg::WORD_WIDTH,
    parameter int SRAM_ADDR_WIDTH = sram_controller_pkg::SRAM_ADDR_WIDTH,
    parameter int SRAM_DATA_WIDTH = sram_controller_pkg::SRAM_DATA_WIDTH,
    parameter int WAIT_CYCLES     = 1,
    parameter int MEM_BASE        = sram_controller_pkg::MEM_BASE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_en,
    input  logic                       wr_en,
    input  logic [WORD_WIDTH-1:0]      address,
    input  logic [WORD_WIDTH-1:0]      write_data,
    output logic [WORD_WIDTH-1:0]      read_data,
    output logic                       ready,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
    output logic                       sram_dq_oe,
    input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
    output logic                       sram_we_n,
    output logic                       sram_oe_n
);
    import sram_controller_pkg::*;

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDX_W = SRAM_ADDR_WIDTH - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       op_wr_q, op_wr_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [WORD_WIDTH-1:0]      wdata_q, wdata_d;
    logic [WORD_WIDTH-1:0]      rdata_q, rdata_d;
    logic [SRAM_ADDR_WIDTH-1:0] saddr_q, saddr_d;
    logic [SRAM_DATA_WIDTH-1:0] sdq_q, sdq_d;
    logic                       soe_q, soe_d;
    logic                       we_n_q, we_n_d;
    logic                       oe_n_q, oe_n_d;

    logic                  req;
    logic                  last;
    logic [WORD_WIDTH-1:0] offset;

    assign req    = rd_en | wr_en;
    assign last   = (cnt_q == CNT_LAST);
    assign offset = address - WORD_WIDTH'(MEM_BASE);

    // Next-state, wait counter, request latch and read-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = LO;
                cnt_d   = '0;
                op_wr_d = wr_en;                // write wins when both are set
                idx_d   = IDX_W'(offset >> 2);  // wraps silently outside the SRAM
                wdata_d = write_data;
            end
            LO: if (last) begin
                state_d = HI;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            HI: if (last) begin
                state_d = DONE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // The SRAM has had the whole phase to settle; sample on its last cycle.
        if (!op_wr_q && last && state_q == LO)
            rdata_d[SRAM_DATA_WIDTH-1:0] = sram_dq_in;
        if (!op_wr_q && last && state_q == HI)
            rdata_d[WORD_WIDTH-1:SRAM_DATA_WIDTH] = sram_dq_in;
    end

    // SRAM pin values for the coming cycle, decoded from next state so the pins
    // come straight from flops and never glitch.
    always_comb begin
        saddr_d = '0;
        sdq_d   = '0;
        soe_d   = 1'b0;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        if (state_d == LO || state_d == HI) begin
            saddr_d = {idx_d, state_d == HI};
            if (op_wr_d) begin
                sdq_d  = (state_d == HI) ? wdata_d[WORD_WIDTH-1:SRAM_DATA_WIDTH]
                                         : wdata_d[SRAM_DATA_WIDTH-1:0];
                soe_d  = 1'b1;
                // Release we_n on the final phase cycle so data is held past the strobe.
                we_n_d = (cnt_d == CNT_LAST);
            end else begin
                oe_n_d = 1'b0;
            end
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            saddr_q <= '0;
            sdq_q   <= '0;
            soe_q   <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            saddr_q <= saddr_d;
            sdq_q   <= sdq_d;
            soe_q   <= soe_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
        end
    end

    // Stall while a request is pending or in flight; held high during reset so
    // the pipeline is not frozen by a controller that is being cleared.
    assign ready = !rst || (state_q == IDLE && !req) || (state_q == DONE);

    assign read_data   = rdata_q;
    assign sram_addr   = saddr_q;
    assign sram_dq_out = sdq_q;
    assign sram_dq_oe  = soe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: behavioural 256K x 16 SRAM, vector table, hand
// sequences for multi-cycle corners, and random traffic against a word model.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    // Second instance with longer phases; its SRAM always returns a fixed pattern.
    logic        rd_en3 = 1'b0, wr_en3 = 1'b0;
    logic [31:0] address3 = 32'd1024, write_data3 = '0;
    logic [31:0] read_data3;
    logic        ready3;
    logic [17:0] sram_addr3;
    logic [15:0] sram_dq_out3, sram_dq_in3;
    logic        sram_dq_oe3, sram_we_n3, sram_oe_n3;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    sram_controller #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .rd_en(rd_en3), .wr_en(wr_en3), .address(address3),
        .write_data(write_data3), .read_data(read_data3), .ready(ready3),
        .sram_addr(sram_addr3), .sram_dq_out(sram_dq_out3), .sram_dq_oe(sram_dq_oe3),
        .sram_dq_in(sram_dq_in3), .sram_we_n(sram_we_n3), .sram_oe_n(sram_oe_n3)
    );
    assign sram_dq_in3 = 16'hA55A;

    // Behavioural SRAM: asynchronous read, write on the rising edge of we_n.
    logic [15:0] mem [0:262143];
    always @(posedge sram_we_n) if (sram_dq_oe) mem[sram_addr] <= sram_dq_out;
    assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Word-level reference: a CPU word lives at word index (addr-base)/4 mod 2^17.
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = '0;

    function automatic int widx(input logic [31:0] a);
        return int'(((a - 32'd1024) >> 2) & 32'h1FFFF);
    endfunction

    function automatic void model_txn(input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (wr) ref_mem[widx(a)] = d;
        else    last_rd = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'h0;
    endfunction

    // One request held until ready; reports stall length and read_data in DONE.
    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, output int low, output logic [31:0] rdat);
        @(posedge clk); #1;
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) break;
            low++;
        end
        rdat = read_data;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] lo;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vt [8];
    int          low;
    logic [31:0] rdat, r0, r1;
    logic [11:0] pat;

    initial begin
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;

        // Reset with both requests asserted.
        rd_en = 1'b1; wr_en = 1'b1; address = 32'd1024; write_data = 32'hFFFF_FFFF;
        #12;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_sram_addr", sram_addr, 18'h0);
        chk("rst_dq_out", sram_dq_out, 16'h0);
        chk("rst_dq_oe", sram_dq_oe, 1'b0);
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_oe_n", sram_oe_n, 1'b1);
        rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); chk("post_rst_ready", ready, 1'b1);
        @(negedge clk); chk("post_rst_ready2", ready, 1'b1);

        // Longer-phase instance: 2*(3+1)+1 = 9 stall cycles.
        @(posedge clk); #1; rd_en3 = 1'b1;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready3) break;
            low++;
        end
        chk("w3_stall", low, 9);
        chk("w3_read_data", read_data3, 32'hA55A_A55A);
        @(posedge clk); #1; rd_en3 = 1'b0;

        // Vector table.
        vt[0] = '{1'b1, 1'b0, 32'd1024,   32'hDEADBEEF, 18'd0,       32'h0};
        vt[1] = '{1'b0, 1'b1, 32'd1024,   32'h0,        18'd0,       32'hDEADBEEF};
        vt[2] = '{1'b1, 1'b0, 32'd1036,   32'h12345678, 18'd6,       32'hDEADBEEF};
        vt[3] = '{1'b0, 1'b1, 32'd1037,   32'h0,        18'd6,       32'h12345678};
        vt[4] = '{1'b1, 1'b0, 32'd1020,   32'hCAFEF00D, 18'h3FFFE,   32'h12345678};
        vt[5] = '{1'b0, 1'b1, 32'd1020,   32'h0,        18'h3FFFE,   32'hCAFEF00D};
        vt[6] = '{1'b0, 1'b1, 32'd525312, 32'h0,        18'd0,       32'hDEADBEEF};
        vt[7] = '{1'b1, 1'b1, 32'd1028,   32'h0BADC0DE, 18'd2,       32'hDEADBEEF};
        for (int v = 0; v < 8; v++) begin
            run_txn(vt[v].wr, vt[v].rd, vt[v].addr, vt[v].wdata, low, rdat);
            model_txn(vt[v].wr, vt[v].addr, vt[v].wdata);
            chk($sformatf("vec%0d_stall", v), low, 5);
            chk($sformatf("vec%0d_read_data", v), rdat, vt[v].exp_rd);
            if (vt[v].wr) begin
                chk($sformatf("vec%0d_sram_lo", v), {16'h0, mem[vt[v].lo]}, {16'h0, vt[v].wdata[15:0]});
                chk($sformatf("vec%0d_sram_hi", v), {16'h0, mem[vt[v].lo + 18'd1]}, {16'h0, vt[v].wdata[31:16]});
            end
        end

        // Back-to-back loads with rd_en held throughout.
        @(posedge clk); #1; rd_en = 1'b1; address = 32'd1024;
        pat = '0; r0 = '0; r1 = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat[i] = ready;
            if (i == 5) begin r0 = read_data; address = 32'd1028; end
            if (i == 11) r1 = read_data;
        end
        @(posedge clk); #1; rd_en = 1'b0;
        last_rd = 32'h0BADC0DE;
        chk("b2b_ready_pattern", {20'h0, pat}, 32'h820);
        chk("b2b_word0", r0, 32'hDEADBEEF);
        chk("b2b_word1", r1, 32'h0BADC0DE);

        // Address and data changed mid-transaction are ignored.
        @(posedge clk); #1; wr_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
        @(negedge clk); @(negedge clk);
        address = 32'd1100; write_data = 32'h33334444;
        low = 2;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) break;
            low++;
        end
        @(posedge clk); #1; wr_en = 1'b0;
        model_txn(1'b1, 32'd1040, 32'h11112222);
        chk("hold_stall", low, 5);
        chk("hold_lo", {16'h0, mem[8]}, 32'h2222);
        chk("hold_hi", {16'h0, mem[9]}, 32'h1111);
        chk("hold_other", {mem[39], mem[38]}, 32'h0);
        chk("hold_read_data", read_data, 32'h0BADC0DE);

        // Reset during the high-half write phase.
        @(posedge clk); #1; wr_en = 1'b1; address = 32'd1044; write_data = 32'h55556666;
        @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
        chk("midrst_we_low_in_hi", sram_we_n, 1'b0);
        chk("midrst_addr_hi", sram_addr, 18'd11);
        rst = 1'b0; #1;
        chk("midrst_we_n", sram_we_n, 1'b1);
        chk("midrst_dq_oe", sram_dq_oe, 1'b0);
        chk("midrst_addr", sram_addr, 18'd0);
        chk("midrst_read_data", read_data, 32'h0);
        wr_en = 1'b0; #2; rst = 1'b1;
        last_rd = 32'h0;
        @(negedge clk); chk("midrst_idle_ready", ready, 1'b1);
        run_txn(1'b1, 1'b0, 32'd1044, 32'h77778888, low, rdat);
        model_txn(1'b1, 32'd1044, 32'h77778888);
        chk("midrst_rewrite_stall", low, 5);

        // Random traffic against the word model.
        for (int n = 0; n < 40; n++) begin
            int          op;
            logic [31:0] a, d;
            op = int'($urandom_range(0, 2));
            a  = 32'd1024 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
            d  = $urandom;
            run_txn(op != 1, op != 0, a, d, low, rdat);
            model_txn(op != 1, a, d);
            chk($sformatf("rnd%0d_stall", n), low, 5);
            chk($sformatf("rnd%0d_read_data", n), rdat, last_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
